// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: constants and FSM state encoding shared by the stream loader and axis2fifo
package axis_fifo_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: synchronous FIFO storage with pointers, occupancy and a registered pop port
// Ports: clk, rst_n (async, active-low); push/din write side; read pop request;
//        dout/dout_valid registered pop result; empty, full, count occupancy status.
module sync_fifo_mem #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             read,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic pop;
    assign pop = read && !empty;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            dout <= '0;
            dout_valid <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            dout_valid <= pop;
            dout <= pop ? mem[rd_ptr] : dout;
        end
    end
endmodule

// File: rtl/axis2fifo.sv
// axis2fifo: AXI-Stream slave capturing one tlast-terminated frame per start into a pop-style FIFO
// Ports: clk, rst_n (async, active-low); start arms a frame capture from IDLE;
//        m_axis_* stream input with tready backpressure; read pops one word into
//        dout/dout_last with a dout_valid pulse; empty/full/count occupancy;
//        frame_done pulse and frame_len when a frame is received and drained;
//        underflow sticky flag for reads while empty (cleared by an accepted start).
module axis2fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                  m_axis_tvalid,
    output logic                  m_axis_tready,
    input  logic                  m_axis_tlast,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  frame_done,
    output logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  underflow
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RECV = RECV;
    localparam logic [1:0] S_DRAIN = DRAIN;
    logic [1:0] state;
    logic [LEN_WIDTH-1:0] len_cnt;
    logic [DATA_WIDTH:0] rd_word;
    logic push, go;
    // tready comes from registers only; full uses the pre-pop count so a full FIFO never takes a push
    assign m_axis_tready = state == S_RECV && !full;
    assign push = m_axis_tvalid && m_axis_tready;
    assign go = state == S_IDLE && start;
    assign dout = rd_word[DATA_WIDTH-1:0];
    assign dout_last = rd_word[DATA_WIDTH];
    sync_fifo_mem #(.WIDTH(DATA_WIDTH + 1), .DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_mem (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .din({m_axis_tlast, m_axis_tdata}),
        .read(read),
        .dout(rd_word),
        .dout_valid(dout_valid),
        .empty(empty),
        .full(full),
        .count(count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            len_cnt <= '0;
            frame_done <= 1'b0;
            frame_len <= '0;
            underflow <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underflow <= (underflow && !go) || (read && empty);
            case (state)
                S_IDLE: begin
                    state <= start ? S_RECV : S_IDLE;
                    len_cnt <= start ? '0 : len_cnt;
                end
                S_RECV: begin
                    // saturate rather than wrap so oversize frames report the maximum length
                    len_cnt <= (push && !(&len_cnt)) ? len_cnt + LEN_WIDTH'(1) : len_cnt;
                    state <= (push && m_axis_tlast) ? S_DRAIN : S_RECV;
                end
                S_DRAIN: begin
                    // a pop racing the tlast push leaves entries behind, so wait for true empty
                    state <= empty ? S_IDLE : S_DRAIN;
                    frame_done <= empty;
                    frame_len <= empty ? len_cnt : frame_len;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis2fifo.sv
// tb_axis2fifo: directed self-checking bench for axis2fifo
module tb_axis2fifo;
    import axis_fifo_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [31:0] m_axis_tdata = '0;
    logic m_axis_tvalid = 1'b0;
    logic m_axis_tready;
    logic m_axis_tlast = 1'b0;
    logic read = 1'b0;
    logic [31:0] dout;
    logic dout_valid, dout_last, empty, full, frame_done, underflow;
    logic [2:0] count;
    logic [15:0] frame_len;
    int tests = 0;
    int fails = 0;
    logic [32:0] cap_q[$];
    int done_cnt = 0;
    int max_cnt = 0;
    int bp_viol = 0;
    bit track = 0;

    axis2fifo dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .read(read), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .empty(empty), .full(full), .count(count),
        .frame_done(frame_done), .frame_len(frame_len), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_valid) cap_q.push_back({dout_last, dout});
        if (frame_done) done_cnt++;
        if (track && int'(count) > max_cnt) max_cnt = int'(count);
        if (full && m_axis_tready) bp_viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_frame(input int n, input logic [31:0] base, input logic [31:0] step, output bit to);
        int k = 0;
        int guard = 0;
        bit acc;
        to = 0;
        while (k < n && !to) begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata = base + 32'(k) * step;
            m_axis_tlast = (k == n - 1);
            acc = m_axis_tready;
            @(negedge clk);
            if (acc) k++;
            guard++;
            if (guard > 200) to = 1;
        end
        m_axis_tvalid = 1'b0;
        m_axis_tlast = 1'b0;
    endtask

    task automatic read_n(input int n, input int delay, output bit to);
        int issued = 0;
        int guard = 0;
        to = 0;
        repeat (delay) @(negedge clk);
        while (issued < n && !to) begin
            read = !empty;
            if (!empty) issued++;
            @(negedge clk);
            guard++;
            if (guard > 200) to = 1;
        end
        read = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (m_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b expected 0", m_axis_tready); end
        tests++; if ({dout_valid, dout_last, dout} !== 34'h0) begin fails++; $display("FAIL reset_dout: got %b/%b/%h expected 0/0/0", dout_valid, dout_last, dout); end
        tests++; if ({empty, full, count} !== 5'b10000) begin fails++; $display("FAIL reset_status: got empty=%b full=%b count=%0d expected 1/0/0", empty, full, count); end
        tests++; if ({frame_done, underflow, frame_len} !== 18'h0) begin fails++; $display("FAIL reset_frame: got done=%b uf=%b len=%0d expected 0/0/0", frame_done, underflow, frame_len); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to1, to2;
        logic [32:0] e;
        cap_q.delete(); done_cnt = 0;
        pulse_start();
        tests++; if (m_axis_tready !== 1'b1) begin fails++; $display("FAIL basic_tready: got %b expected 1", m_axis_tready); end
        drive_frame(4, 32'hA0, 32'h1, to1);
        tests++; if ({full, count} !== 4'b1100) begin fails++; $display("FAIL basic_full: got full=%b count=%0d expected 1/4", full, count); end
        tests++; if (dut.state !== DRAIN || m_axis_tready !== 1'b0) begin fails++; $display("FAIL basic_drain: got state=%0d tready=%b expected 2/0", dut.state, m_axis_tready); end
        read_n(4, 0, to2);
        repeat (3) @(negedge clk);
        #1;
        tests++; if ({to1, to2} !== 2'b00) begin fails++; $display("FAIL basic_timeout: got %b expected 00", {to1, to2}); end
        tests++; if (cap_q.size() !== 4) begin fails++; $display("FAIL basic_count: got %0d words expected 4", cap_q.size()); end
        for (int i = 0; i < 4; i++) begin
            e = {i == 3, 32'hA0 + 32'(i)};
            tests++; if (cap_q[i] !== e) begin fails++; $display("FAIL basic_word%0d: got %h expected %h", i, cap_q[i], e); end
        end
        tests++; if (done_cnt !== 1 || frame_len !== 16'd4) begin fails++; $display("FAIL basic_done: got pulses=%0d len=%0d expected 1/4", done_cnt, frame_len); end
    endtask

    task automatic test_backpressure();
        bit to1, to2;
        logic [32:0] e;
        cap_q.delete(); done_cnt = 0; max_cnt = 0; bp_viol = 0; track = 1;
        pulse_start();
        fork
            drive_frame(6, 32'hB0, 32'h1, to1);
            read_n(6, 8, to2);
        join
        repeat (3) @(negedge clk);
        #1;
        track = 0;
        tests++; if ({to1, to2} !== 2'b00) begin fails++; $display("FAIL bp_timeout: got %b expected 00", {to1, to2}); end
        tests++; if (max_cnt !== 4 || bp_viol !== 0) begin fails++; $display("FAIL bp_full: got max=%0d viol=%0d expected 4/0", max_cnt, bp_viol); end
        tests++; if (cap_q.size() !== 6) begin fails++; $display("FAIL bp_count: got %0d words expected 6", cap_q.size()); end
        for (int i = 0; i < 6; i++) begin
            e = {i == 5, 32'hB0 + 32'(i)};
            tests++; if (cap_q[i] !== e) begin fails++; $display("FAIL bp_word%0d: got %h expected %h", i, cap_q[i], e); end
        end
        tests++; if (done_cnt !== 1 || frame_len !== 16'd6) begin fails++; $display("FAIL bp_done: got pulses=%0d len=%0d expected 1/6", done_cnt, frame_len); end
    endtask

    task automatic test_concurrent();
        bit to1, to2;
        logic [32:0] e;
        cap_q.delete(); done_cnt = 0; max_cnt = 0; track = 1;
        pulse_start();
        fork
            drive_frame(10, 32'hC0, 32'h1, to1);
            read_n(10, 0, to2);
        join
        repeat (3) @(negedge clk);
        #1;
        track = 0;
        tests++; if ({to1, to2} !== 2'b00) begin fails++; $display("FAIL cc_timeout: got %b expected 00", {to1, to2}); end
        tests++; if (max_cnt !== 1) begin fails++; $display("FAIL cc_maxcount: got %0d expected 1", max_cnt); end
        tests++; if (cap_q.size() !== 10) begin fails++; $display("FAIL cc_count: got %0d words expected 10", cap_q.size()); end
        for (int i = 0; i < 10; i++) begin
            e = {i == 9, 32'hC0 + 32'(i)};
            tests++; if (cap_q[i] !== e) begin fails++; $display("FAIL cc_word%0d: got %h expected %h", i, cap_q[i], e); end
        end
        tests++; if (done_cnt !== 1 || frame_len !== 16'd10) begin fails++; $display("FAIL cc_done: got pulses=%0d len=%0d expected 1/10", done_cnt, frame_len); end
    endtask

    task automatic test_underflow();
        bit to;
        cap_q.delete(); done_cnt = 0;
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL uf_pre: got %b expected 0", underflow); end
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        tests++; if (underflow !== 1'b1 || dout_valid !== 1'b0) begin fails++; $display("FAIL uf_set: got uf=%b dv=%b expected 1/0", underflow, dout_valid); end
        m_axis_tvalid = 1'b1; m_axis_tdata = 32'hDEAD;
        repeat (2) @(negedge clk);
        tests++; if (m_axis_tready !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL idle_tvalid: got tready=%b empty=%b expected 0/1", m_axis_tready, empty); end
        m_axis_tvalid = 1'b0;
        pulse_start();
        tests++; if (underflow !== 1'b0 || m_axis_tready !== 1'b1) begin fails++; $display("FAIL uf_clear: got uf=%b tready=%b expected 0/1", underflow, m_axis_tready); end
        m_axis_tvalid = 1'b1; m_axis_tdata = 32'hD0;
        @(negedge clk);
        m_axis_tdata = 32'hD1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; m_axis_tdata = 32'hD2; m_axis_tlast = 1'b1;
        @(negedge clk);
        m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0;
        read_n(3, 0, to);
        repeat (3) @(negedge clk);
        #1;
        tests++; if (to !== 1'b0 || cap_q.size() !== 3) begin fails++; $display("FAIL stray_count: got to=%b words=%0d expected 0/3", to, cap_q.size()); end
        tests++; if (cap_q[2] !== {1'b1, 32'hD2}) begin fails++; $display("FAIL stray_last: got %h expected %h", cap_q[2], {1'b1, 32'hD2}); end
        tests++; if (done_cnt !== 1 || frame_len !== 16'd3) begin fails++; $display("FAIL stray_start: got pulses=%0d len=%0d expected 1/3", done_cnt, frame_len); end
    endtask

    task automatic test_reset_mid();
        bit to1, to2;
        pulse_start();
        m_axis_tvalid = 1'b1; m_axis_tdata = 32'h100;
        @(negedge clk);
        m_axis_tdata = 32'h101;
        @(negedge clk);
        m_axis_tvalid = 1'b0;
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL rm_pre: got count=%0d expected 2", count); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (m_axis_tready !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin fails++; $display("FAIL rm_async: got tready=%b count=%0d empty=%b expected 0/0/1", m_axis_tready, count, empty); end
        tests++; if (dut.state !== IDLE || frame_len !== 16'd0) begin fails++; $display("FAIL rm_state: got state=%0d len=%0d expected 0/0", dut.state, frame_len); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        cap_q.delete(); done_cnt = 0;
        pulse_start();
        drive_frame(2, 32'h11, 32'h11, to1);
        read_n(2, 0, to2);
        repeat (3) @(negedge clk);
        #1;
        tests++; if ({to1, to2} !== 2'b00 || cap_q.size() !== 2) begin fails++; $display("FAIL rm_count: got to=%b words=%0d expected 00/2", {to1, to2}, cap_q.size()); end
        tests++; if (cap_q[0] !== {1'b0, 32'h11} || cap_q[1] !== {1'b1, 32'h22}) begin fails++; $display("FAIL rm_words: got %h %h expected 011 100000022", cap_q[0], cap_q[1]); end
        tests++; if (done_cnt !== 1 || frame_len !== 16'd2) begin fails++; $display("FAIL rm_done: got pulses=%0d len=%0d expected 1/2", done_cnt, frame_len); end
    endtask

    task automatic test_single();
        bit to1, to2;
        cap_q.delete(); done_cnt = 0;
        pulse_start();
        drive_frame(1, 32'h5A, 32'h1, to1);
        tests++; if (dut.state !== DRAIN || count !== 3'd1) begin fails++; $display("FAIL single_drain: got state=%0d count=%0d expected 2/1", dut.state, count); end
        @(negedge clk);
        #1;
        tests++; if (done_cnt !== 0) begin fails++; $display("FAIL single_early: got pulses=%0d expected 0", done_cnt); end
        read_n(1, 0, to2);
        repeat (3) @(negedge clk);
        #1;
        tests++; if ({to1, to2} !== 2'b00 || cap_q.size() !== 1) begin fails++; $display("FAIL single_count: got to=%b words=%0d expected 00/1", {to1, to2}, cap_q.size()); end
        tests++; if (cap_q[0] !== {1'b1, 32'h5A}) begin fails++; $display("FAIL single_word: got %h expected 10000005a", cap_q[0]); end
        tests++; if (done_cnt !== 1 || frame_len !== 16'd1 || dut.state !== IDLE) begin fails++; $display("FAIL single_done: got pulses=%0d len=%0d state=%0d expected 1/1/0", done_cnt, frame_len, dut.state); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_concurrent();
        test_underflow();
        test_reset_mid();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
